gate_actuator: RTL
==================

# gate_actuator

Gate actuator controller for the parking entrance barrier. It accepts open/close commands from the access controller and drives the barrier motor up or down. It uses up/down limit switches and an obstruction sensor, with travel timeouts, a bounded obstruction-retry count, and a latched fault state. It sits between the entrance controller's open_gate/close_gate outputs and the motor driver.

## Interface
- MAX_TRAVEL, 32: maximum cycles spent in any motion state before a fault; must be ≥ 2.
- RETRY_LIMIT, 2: number of obstruction-triggered reopen attempts allowed per close cycle.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset rst, synchronous, active-high.
- open_cmd  in  1  request to raise the barrier (level, sampled every edge).
- close_cmd  in  1  request to lower the barrier (level).
- lim_up  in  1  barrier fully raised.
- lim_down  in  1  barrier fully lowered.
- obstruct  in  1  object detected under the barrier.
- fault_clr  in  1  clears the FAULT state.
- motor_up  out  1  drive motor upward.
- motor_down  out  1  drive motor downward.
- gate_open  out  1  barrier at rest, raised.
- gate_closed  out  1  barrier at rest, lowered.
- busy  out  1  barrier in motion.
- fault  out  1  latched fault.

## Operation
- States: HOMING, CLOSED, OPENING, OPEN, CLOSING, FAULT.
- Output decode:
  - HOMING: motor_down=1, busy=1.
  - OPENING: motor_up=1, busy=1.
  - CLOSING: motor_down=1, busy=1.
  - OPEN: gate_open=1.
  - CLOSED: gate_closed=1.
  - FAULT: fault=1.
  - All other outputs are 0. motor_up and motor_down are never 1 together.
- Global rule, all states except FAULT: lim_up && lim_down → FAULT. This has the highest priority.
- HOMING: lim_down → CLOSED; obstruct → FAULT; timeout → FAULT.
- CLOSED, in priority order: open_cmd → OPENING; !lim_down → HOMING. close_cmd is ignored.
- OPENING: lim_up → OPEN; timeout → FAULT. close_cmd is ignored; no command is latched.
- OPEN, in priority order: !lim_up → OPENING; close_cmd && !open_cmd && !obstruct → CLOSING. If obstruct is high, the barrier stays OPEN.
- CLOSING, in priority order:
  1. lim_down → CLOSED, and retry_cnt ← 0.
  2. open_cmd → OPENING; retry_cnt is unchanged.
  3. obstruct: if retry_cnt == RETRY_LIMIT → FAULT; otherwise retry_cnt+1 → OPENING.
  4. timeout → FAULT.
- FAULT: fault_clr → HOMING, and retry_cnt ← 0. All other inputs are ignored.
- Travel counter:
  - Width is clog2(MAX_TRAVEL).
  - Cleared to 0 on every transition into HOMING, OPENING or CLOSING.
  - Increments once per cycle while in a motion state.
  - Timeout means travel_cnt == MAX_TRAVEL-1 with the target limit not asserted, so motion lasts at most MAX_TRAVEL cycles.
  - A limit switch asserted in the same cycle as the timeout wins.
- Retry counter: width clog2(RETRY_LIMIT+1); it saturates by design and never wraps.

## Timing
- Reset: at any edge with rst=1, state ← HOMING, counters ← 0, and all outputs ← 0. rst overrides any state, including mid-motion.
- Outputs are registered as decode(nxt_state). From the first non-reset edge onward they always reflect the state register. The single exception is the cycle immediately after reset, where all outputs are 0.
- Latency: an input sampled at edge N changes state and outputs at edge N; the new values are visible in cycle N+1. There are no extra pipeline stages.
- Simultaneous open_cmd and close_cmd: open wins in every state.
- Commands are levels, not pulses. A held close_cmd in OPEN re-triggers closing once obstruct falls.
- The limit-loss checks (CLOSED with !lim_down, OPEN with !lim_up) take effect at the first edge the switch reads 0.

## Test plan
Run with MAX_TRAVEL=8 and RETRY_LIMIT=2.
- Homing: release rst, assert lim_down on the 3rd cycle after release. Required: cycle 1 all outputs 0; cycles 2–3 motor_down=1 and busy=1; then gate_closed=1 and motor_down=0.
- Open: from CLOSED, pulse open_cmd 1 cycle, assert lim_up 4 cycles later. Required: motor_up=1 from the next cycle, then gate_open=1 and motor_up=0. close_cmd pulsed mid-travel has no effect.
- Timeout: from CLOSED, raise open_cmd and never assert lim_up. Required: motor_up=1 for exactly 8 cycles, then fault=1. Then fault_clr → motor_down=1 (HOMING).
- Obstruction retries: three consecutive OPEN→CLOSING cycles, each with obstruct pulsed mid-close. Required: first two return to OPENING; third → fault=1. A close that reaches lim_down resets the count.
- Sensor conflict: in OPEN, assert lim_up and lim_down together. Required: fault=1 next cycle. Separately, in CLOSED with open_cmd=close_cmd=1, required: motor_up=1.
- Reset mid-close: assert rst for 1 cycle during CLOSING. Required: all outputs 0 for 1 cycle, then motor_down=1 (HOMING) with retry_cnt=0.

Source files
------------

// File: rtl/gate_actuator.sv
// Parking entrance barrier controller: turns open/close commands into motor
// drive, supervised by limit switches, an obstruction sensor, per-move travel
// timeouts, a bounded obstruction-retry count and a latched fault.
module gate_actuator #(
  parameter int MAX_TRAVEL  = 32,
  parameter int RETRY_LIMIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic open_cmd,
  input  logic close_cmd,
  input  logic lim_up,
  input  logic lim_down,
  input  logic obstruct,
  input  logic fault_clr,
  output logic motor_up,
  output logic motor_down,
  output logic gate_open,
  output logic gate_closed,
  output logic busy,
  output logic fault
);

  localparam int TW = $clog2(MAX_TRAVEL);
  localparam int RW = (RETRY_LIMIT > 0) ? $clog2(RETRY_LIMIT + 1) : 1;

  localparam logic [TW-1:0] TRAVEL_LAST = TW'(MAX_TRAVEL - 1);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(RETRY_LIMIT);

  localparam logic [2:0] S_HOMING  = 3'd0;
  localparam logic [2:0] S_CLOSED  = 3'd1;
  localparam logic [2:0] S_OPENING = 3'd2;
  localparam logic [2:0] S_OPEN    = 3'd3;
  localparam logic [2:0] S_CLOSING = 3'd4;
  localparam logic [2:0] S_FAULT   = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] travel_q, travel_d;
  logic [RW-1:0] retry_q, retry_d;
  // {motor_up, motor_down, gate_open, gate_closed, busy, fault}
  logic [5:0]    out_q, out_d;

  logic timeout;
  logic moving_q, moving_d;

  assign timeout  = (travel_q == TRAVEL_LAST);
  assign moving_q = (state_q == S_HOMING) || (state_q == S_OPENING) ||
                    (state_q == S_CLOSING);
  assign moving_d = (state_d == S_HOMING) || (state_d == S_OPENING) ||
                    (state_d == S_CLOSING);

  // Next-state and retry bookkeeping; a limit switch always beats a timeout
  // because the limit test comes first in every motion state.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    if (state_q != S_FAULT && lim_up && lim_down) begin
      state_d = S_FAULT;
    end else begin
      case (state_q)
        S_HOMING: begin
          if (lim_down)               state_d = S_CLOSED;
          else if (obstruct || timeout) state_d = S_FAULT;
        end
        S_CLOSED: begin
          if (open_cmd)       state_d = S_OPENING;
          else if (!lim_down) state_d = S_HOMING;
        end
        S_OPENING: begin
          if (lim_up)       state_d = S_OPEN;
          else if (timeout) state_d = S_FAULT;
        end
        S_OPEN: begin
          if (!lim_up)                                  state_d = S_OPENING;
          else if (close_cmd && !open_cmd && !obstruct) state_d = S_CLOSING;
        end
        S_CLOSING: begin
          if (lim_down) begin
            state_d = S_CLOSED;
            retry_d = '0;
          end else if (open_cmd) begin
            state_d = S_OPENING;
          end else if (obstruct) begin
            if (retry_q == RETRY_MAX) begin
              state_d = S_FAULT;
            end else begin
              state_d = S_OPENING;
              retry_d = retry_q + 1'b1;
            end
          end else if (timeout) begin
            state_d = S_FAULT;
          end
        end
        S_FAULT: begin
          if (fault_clr) begin
            state_d = S_HOMING;
            retry_d = '0;
          end
        end
        default: state_d = S_FAULT;
      endcase
    end
  end

  // Travel counter restarts on entry to a motion state and counts while moving.
  always_comb begin
    travel_d = '0;
    if (moving_d && state_d != state_q) travel_d = '0;
    else if (moving_d && moving_q)      travel_d = travel_q + 1'b1;
  end

  // Output decode of the state being entered, so outputs land with the state.
  always_comb begin
    out_d = 6'b000000;
    case (state_d)
      S_HOMING:  out_d = 6'b010010;
      S_OPENING: out_d = 6'b100010;
      S_CLOSING: out_d = 6'b010010;
      S_OPEN:    out_d = 6'b001000;
      S_CLOSED:  out_d = 6'b000100;
      S_FAULT:   out_d = 6'b000001;
      default:   out_d = 6'b000001;
    endcase
  end

  // State, counters and registered outputs; reset forces homing with outputs low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_HOMING;
      travel_q <= '0;
      retry_q  <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      travel_q <= travel_d;
      retry_q  <= retry_d;
      out_q    <= out_d;
    end
  end

  assign {motor_up, motor_down, gate_open, gate_closed, busy, fault} = out_q;

endmodule
